// File: rtl/pattern_serializer.sv
// Serial stimulus source for the glitch filter: a word accepted through valid/ready is sent LSB first, each bit held HOLD clocks.
// Optional continuous rotation of the word is built when PATTERN_SERIALIZER_REPEAT_EN is defined.
//
// state | meaning
// IDLE  | line at IDLE_LEVEL, ready for a word (the first IDLE cycle after a word carries done)
// SHIFT | word in progress, current bit on sig_out
module pattern_serializer #(
    parameter int   WIDTH      = 16,
    parameter int   HOLD       = 4,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
`ifdef PATTERN_SERIALIZER_REPEAT_EN
    // named repeat_en because "repeat" is a reserved word
    input  logic             repeat_en,
`endif
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] data_in,
    output logic             sig_out,
    output logic             busy,
    output logic             done
);

    localparam int HCW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam int BCW = $clog2(WIDTH);

    localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD - 1);
    localparam logic [BCW-1:0] BIT_LAST  = BCW'(WIDTH - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shift_reg;
    logic [BCW-1:0]   bit_cnt;
    logic [HCW-1:0]   hold_cnt;
`ifdef PATTERN_SERIALIZER_REPEAT_EN
    logic [WIDTH-1:0] word_copy;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            hold_cnt   <= '0;
            sig_out    <= IDLE_LEVEL;
            load_ready <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef PATTERN_SERIALIZER_REPEAT_EN
            word_copy  <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_valid) begin
                        shift_reg  <= data_in;
`ifdef PATTERN_SERIALIZER_REPEAT_EN
                        word_copy  <= data_in;
`endif
                        bit_cnt    <= '0;
                        hold_cnt   <= '0;
                        sig_out    <= data_in[0];
                        busy       <= 1'b1;
                        load_ready <= 1'b0;
                        state      <= SHIFT;
                    end else begin
                        sig_out    <= IDLE_LEVEL;
                        busy       <= 1'b0;
                        load_ready <= 1'b1;
                    end
                end

                SHIFT: begin
                    if (hold_cnt == HOLD_LAST) begin
                        hold_cnt <= '0;
                        if (bit_cnt == BIT_LAST) begin
`ifdef PATTERN_SERIALIZER_REPEAT_EN
                            if (repeat_en) begin
                                // seamless restart: bit 0 follows the last bit with no gap
                                shift_reg <= word_copy;
                                bit_cnt   <= '0;
                                sig_out   <= word_copy[0];
                            end else begin
                                state      <= IDLE;
                                sig_out    <= IDLE_LEVEL;
                                busy       <= 1'b0;
                                load_ready <= 1'b1;
                                done       <= 1'b1;
                            end
`else
                            state      <= IDLE;
                            sig_out    <= IDLE_LEVEL;
                            busy       <= 1'b0;
                            load_ready <= 1'b1;
                            done       <= 1'b1;
`endif
                        end else begin
                            shift_reg <= shift_reg >> 1;
                            bit_cnt   <= bit_cnt + 1'b1;
                            sig_out   <= shift_reg[1];
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end

                default: begin
                    state      <= IDLE;
                    sig_out    <= IDLE_LEVEL;
                    busy       <= 1'b0;
                    load_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_serializer.sv
// Directed bench for pattern_serializer: one HOLD=1 and one HOLD=4 instance driven by a linear step sequence.
module tb_pattern_serializer;

    logic        clock;
    logic        reset_a, reset_b;
    logic        lv_a, lv_b;
    logic [15:0] din_a, din_b;
    logic        lr_a, lr_b;
    logic        so_a, so_b;
    logic        busy_a, busy_b;
    logic        done_a, done_b;
`ifdef PATTERN_SERIALIZER_REPEAT_EN
    logic        rep_a, rep_b;
`endif

    int checks = 0;
    int errors = 0;

    pattern_serializer #(.WIDTH(16), .HOLD(1), .IDLE_LEVEL(1'b0)) dut_a (
        .clock      (clock),
        .reset      (reset_a),
`ifdef PATTERN_SERIALIZER_REPEAT_EN
        .repeat_en  (rep_a),
`endif
        .load_valid (lv_a),
        .load_ready (lr_a),
        .data_in    (din_a),
        .sig_out    (so_a),
        .busy       (busy_a),
        .done       (done_a)
    );

    pattern_serializer #(.WIDTH(16), .HOLD(4), .IDLE_LEVEL(1'b0)) dut_b (
        .clock      (clock),
        .reset      (reset_b),
`ifdef PATTERN_SERIALIZER_REPEAT_EN
        .repeat_en  (rep_b),
`endif
        .load_valid (lv_b),
        .load_ready (lr_b),
        .data_in    (din_b),
        .sig_out    (so_b),
        .busy       (busy_b),
        .done       (done_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_n(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // checks the 16 bit periods of a word already accepted on dut_a, then its done cycle
    task automatic check_word_a(input logic [15:0] word);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("a_bit%0d", i), so_a, word[i]);
            check($sformatf("a_busy%0d", i), busy_a, 1'b1);
            check($sformatf("a_ready%0d", i), lr_a, 1'b0);
            tick();
        end
        check("a_done", done_a, 1'b1);
        check("a_done_idle", so_a, 1'b0);
        check("a_done_ready", lr_a, 1'b1);
        check("a_done_busy", busy_a, 1'b0);
    endtask

    task automatic run_word_a(input logic [15:0] word);
        lv_a  = 1'b1;
        din_a = word;
        tick();
        lv_a  = 1'b0;
        check_word_a(word);
        tick();
        check("a_done_one_cycle", done_a, 1'b0);
    endtask

    task automatic wait_done_a(output int n);
        n = 0;
        while (done_a !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        logic [15:0] seq;
        reset_a = 1'b1; reset_b = 1'b1;
        lv_a = 1'b0; lv_b = 1'b0;
        din_a = '0; din_b = '0;
`ifdef PATTERN_SERIALIZER_REPEAT_EN
        rep_a = 1'b0; rep_b = 1'b0;
`endif
        tick();
        tick();
        reset_a = 1'b0; reset_b = 1'b0;

        check("rst_sig_out", so_a, 1'b0);
        check("rst_ready", lr_a, 1'b1);
        check("rst_busy", busy_a, 1'b0);
        check("rst_done", done_a, 1'b0);
        check("rst_b_ready", lr_b, 1'b1);

        // 1: 16'h1D7D, HOLD=1, bits 1,0,1,1,1,1,1,0,1,0,1,1,1,0,0,0
        run_word_a(16'h1D7D);

        // 2: HOLD=4, 16'h0001 -> 4 cycles high, 60 low, done at cycle 65
        lv_b  = 1'b1;
        din_b = 16'h0001;
        tick();
        lv_b  = 1'b0;
        for (int c = 1; c <= 64; c++) begin
            check($sformatf("b_sig_c%0d", c), so_b, (c <= 4) ? 1'b1 : 1'b0);
            check($sformatf("b_busy_c%0d", c), busy_b, 1'b1);
            check($sformatf("b_done_c%0d", c), done_b, 1'b0);
            tick();
        end
        check("b_done_65", done_b, 1'b1);
        check("b_busy_65", busy_b, 1'b0);
        tick();
        check("b_done_66", done_b, 1'b0);

        // 3: back-to-back with load_valid held, done pulses 17 apart
        lv_a  = 1'b1;
        din_a = 16'hFFFF;
        tick();
        din_a = 16'h0000;
        check("b2b_w1_bit0", so_a, 1'b1);
        wait_done_a(n);
        check_n("b2b_first_done_latency", n, 16);
        check("b2b_gap_level", so_a, 1'b0);
        check("b2b_gap_ready", lr_a, 1'b1);
        tick();
        lv_a = 1'b0;
        check("b2b_w2_busy", busy_a, 1'b1);
        check("b2b_w2_bit0", so_a, 1'b0);
        wait_done_a(n);
        check_n("b2b_done_spacing", n + 1, 17);
        tick();

        // 4: reset mid-word at bit 5 of 16'hAAAA
        lv_a  = 1'b1;
        din_a = 16'hAAAA;
        tick();
        lv_a  = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("abort_bit5", so_a, 1'b1);
        reset_a = 1'b1;
        tick();
        reset_a = 1'b0;
        check("abort_sig_out", so_a, 1'b0);
        check("abort_busy", busy_a, 1'b0);
        check("abort_ready", lr_a, 1'b1);
        check("abort_done", done_a, 1'b0);
        for (int i = 0; i < 12; i++) begin
            tick();
            check($sformatf("abort_no_done%0d", i), done_a, 1'b0);
        end
        // reset wins over a simultaneous load
        reset_a = 1'b1;
        lv_a    = 1'b1;
        din_a   = 16'hFFFF;
        tick();
        reset_a = 1'b0;
        lv_a    = 1'b0;
        check("rst_vs_load_busy", busy_a, 1'b0);
        check("rst_vs_load_sig", so_a, 1'b0);
        tick();
        check("rst_vs_load_idle", busy_a, 1'b0);
        run_word_a(16'h1D7D);

        // 5: load_valid while busy is ignored; the pending word is taken in the done cycle
        lv_a  = 1'b1;
        din_a = 16'hC3A5;
        tick();
        din_a = 16'h1234;
        check_word_a(16'hC3A5);
        tick();
        lv_a = 1'b0;
        check_word_a(16'h1234);
        tick();

`ifdef PATTERN_SERIALIZER_REPEAT_EN
        // 6: continuous rotation, then release
        seq   = 16'h1D7D;
        rep_a = 1'b1;
        lv_a  = 1'b1;
        din_a = seq;
        tick();
        lv_a = 1'b0;
        for (int c = 0; c < 48; c++) begin
            check($sformatf("rep_bit%0d", c), so_a, seq[c % 16]);
            check($sformatf("rep_busy%0d", c), busy_a, 1'b1);
            check($sformatf("rep_nodone%0d", c), done_a, 1'b0);
            tick();
        end
        rep_a = 1'b0;
        check_word_a(seq);
        tick();
`else
        seq = 16'h0000;
        check("idle_after_tests", so_a, seq[0]);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
